if_stage_ctrl: RTL and testbench

- Fetch-side counterpart to the hazard detection unit: consumes its `stall` output and acts on it.
- Owns the PC register and the IF/ID pipeline register.
- On a stall it holds the PC and injects NOP bubbles into IF/ID.
- On a branch stall it sits in a wait state until the execute stage resolves the branch, then redirects or falls through.
- Sits between instruction memory and the decode stage; its `if_id_ins` feeds back into the hazard unit.

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 35 +++
 rtl/if_stage_ctrl.sv | 121 ++++++++++++
 tb/tb_if_stage_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Opcode constants, bubble encoding and fetch FSM states shared by the
// fetch-stage controller and the hazard detection unit.
package pipeline_pkg;

    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_REGIMM = 6'b000001;

    localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } if_state_e;

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ) || (op == OP_REGIMM);
    endfunction

    function automatic logic is_load_op(input logic [5:0] op);
        return op == OP_LW;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register (instruction, PC+4, valid). Reset wins over bubble
// injection, which wins over a normal load; with neither the contents hold.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INS = NOP_INS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        inject_nop,
    input  logic [31:0] ins_d,
    input  logic [31:0] pc4_d,
    output logic [31:0] ins,
    output logic [31:0] pc4,
    output logic        valid
);

    // A bubble keeps the old PC+4; only the instruction and valid change.
    always_ff @(posedge clk) begin
        if (rst) begin
            ins   <= NOP_INS;
            pc4   <= 32'h0000_0000;
            valid <= 1'b0;
        end else if (inject_nop) begin
            ins   <= NOP_INS;
            valid <= 1'b0;
        end else if (load) begin
            ins   <= ins_d;
            pc4   <= pc4_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch-stage controller: PC register, IF/ID register, stall bubbles and the
// branch-resolution wait with a bounded timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | normal fetch; stall holds PC and injects one NOP
//   BR_WAIT | branch in flight; NOP every cycle until resolve or timeout
module if_stage_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = NOP_INS_DEFAULT,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      imem_ins,
    input  logic             stall,
    input  logic             br_resolved,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_ins,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             br_timeout
);

    // Wait timer counts down from MAX_WAIT-1; terminal count 0 is the last
    // cycle a resolution can still arrive.
    localparam logic [3:0] WAIT_TC_LOAD = 4'(MAX_WAIT - 1);

    if_state_e   state, state_nxt;
    logic [3:0]  wait_tmr, wait_tmr_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] pc_plus4;
    logic        timeout_nxt;
    logic        load_if_id;
    logic        inject_nop;
    logic        bubble_inc;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        state_nxt    = state;
        wait_tmr_nxt = wait_tmr;
        pc_nxt       = pc;
        timeout_nxt  = br_timeout;
        load_if_id   = 1'b0;
        inject_nop   = 1'b0;
        bubble_inc   = 1'b0;
        case (state)
            RUN: begin
                if (!stall) begin
                    pc_nxt     = pc_plus4;
                    load_if_id = 1'b1;
                end else begin
                    inject_nop = 1'b1;
                    bubble_inc = 1'b1;
                    if (is_branch_op(if_id_ins[31:26])) begin
                        state_nxt    = BR_WAIT;
                        wait_tmr_nxt = WAIT_TC_LOAD;
                    end
                end
            end
            BR_WAIT: begin
                inject_nop = 1'b1;
                bubble_inc = 1'b1;
                if (wait_tmr != 4'd0) begin
                    wait_tmr_nxt = wait_tmr - 4'd1;
                end
                // Resolution has priority over the timeout in the same cycle.
                if (br_resolved) begin
                    state_nxt = RUN;
                    if (br_taken) begin
                        pc_nxt = br_target & 32'hFFFF_FFFC;
                    end
                end else if (wait_tmr == 4'd0) begin
                    state_nxt   = RUN;
                    timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            wait_tmr   <= 4'd0;
            pc         <= RESET_PC;
            bubble_cnt <= '0;
            br_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_tmr   <= wait_tmr_nxt;
            pc         <= pc_nxt;
            br_timeout <= timeout_nxt;
            if (bubble_inc && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    if_id_reg #(
        .NOP_INS(NOP_INS)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_if_id),
        .inject_nop(inject_nop),
        .ins_d     (imem_ins),
        .pc4_d     (pc_plus4),
        .ins       (if_id_ins),
        .pc4       (if_id_pc4),
        .valid     (if_id_valid)
    );

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: per-cycle vectors with expected post-edge state,
// queued when driven and checked after the edge.
module tb_if_stage_ctrl;

    localparam logic [31:0] ADDI   = 32'h2001_0005;
    localparam logic [31:0] LW     = 32'h8C22_0000;
    localparam logic [31:0] BEQ    = 32'h1022_0003;
    localparam logic [31:0] BNE    = 32'h1422_0003;
    localparam logic [31:0] BGTZ   = 32'h1C20_0002;
    localparam logic [31:0] REGIMM = 32'h0441_0004;
    localparam logic [31:0] NOP2   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_ins = 32'h0;
    logic        stall = 1'b0;
    logic        br_resolved = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;

    logic [31:0] pc1, ins1, pc4_1;
    logic        vld1, to1;
    logic [15:0] bub1;
    logic [31:0] pc2, ins2, pc4_2;
    logic        vld2, to2;
    logic [2:0]  bub2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_stage_ctrl dut (
        .clk(clk), .rst(rst), .imem_ins(imem_ins), .stall(stall),
        .br_resolved(br_resolved), .br_taken(br_taken), .br_target(br_target),
        .pc(pc1), .if_id_ins(ins1), .if_id_pc4(pc4_1), .if_id_valid(vld1),
        .bubble_cnt(bub1), .br_timeout(to1)
    );

    // Small counter, single-cycle wait and a reset PC near the top of memory.
    if_stage_ctrl #(
        .RESET_PC(32'hFFFF_FFF8), .NOP_INS(NOP2), .MAX_WAIT(1), .CNT_W(3)
    ) dut2 (
        .clk(clk), .rst(rst), .imem_ins(imem_ins), .stall(stall),
        .br_resolved(br_resolved), .br_taken(br_taken), .br_target(br_target),
        .pc(pc2), .if_id_ins(ins2), .if_id_pc4(pc4_2), .if_id_valid(vld2),
        .bubble_cnt(bub2), .br_timeout(to2)
    );

    typedef struct {
        string       name;
        bit          d2;
        bit          r, st, res, tk;
        logic [31:0] tgt, im;
        logic [31:0] e_pc, e_ins, e_pc4;
        bit          e_vld;
        int          e_bub;
        bit          e_to;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(string name, bit d2, bit r, bit st, bit res, bit tk,
                                logic [31:0] tgt, logic [31:0] im, logic [31:0] e_pc,
                                logic [31:0] e_ins, logic [31:0] e_pc4, bit e_vld,
                                int e_bub, bit e_to);
        vec_t v;
        v.name = name; v.d2 = d2; v.r = r; v.st = st; v.res = res; v.tk = tk;
        v.tgt = tgt; v.im = im; v.e_pc = e_pc; v.e_ins = e_ins; v.e_pc4 = e_pc4;
        v.e_vld = e_vld; v.e_bub = e_bub; v.e_to = e_to;
        return v;
    endfunction

    task automatic check_one();
        vec_t        v;
        logic [31:0] a_pc, a_ins, a_pc4;
        logic        a_vld, a_to;
        int          a_bub;
        bit          ok;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: queue empty, actual=0 entries required=1");
            return;
        end
        v = exp_q.pop_front();
        a_pc  = v.d2 ? pc2 : pc1;
        a_ins = v.d2 ? ins2 : ins1;
        a_pc4 = v.d2 ? pc4_2 : pc4_1;
        a_vld = v.d2 ? vld2 : vld1;
        a_to  = v.d2 ? to2 : to1;
        a_bub = v.d2 ? int'(bub2) : int'(bub1);
        ok = (a_pc == v.e_pc) && (a_ins == v.e_ins) && (a_vld == v.e_vld) &&
             (a_bub == v.e_bub) && (a_to == v.e_to);
        // PC+4 is only meaningful for real instructions and right after reset.
        if (v.e_vld || v.r) ok = ok && (a_pc4 == v.e_pc4);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: actual pc=%h ins=%h pc4=%h valid=%0b bubbles=%0d timeout=%0b, required pc=%h ins=%h pc4=%h valid=%0b bubbles=%0d timeout=%0b",
                     v.name, a_pc, a_ins, a_pc4, a_vld, a_bub, a_to,
                     v.e_pc, v.e_ins, v.e_pc4, v.e_vld, v.e_bub, v.e_to);
        end
    endtask

    task automatic step(input vec_t v);
        rst = v.r; stall = v.st; br_resolved = v.res; br_taken = v.tk;
        br_target = v.tgt; imem_ins = v.im;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        //                name         d2 r  st res tk  tgt          imem    pc            ins     pc4           v  bub to
        tbl.push_back(mk("reset0",     0, 1, 0, 0, 0, 32'h0,        ADDI,   32'h0,        32'h0,  32'h0,        0, 0,  0));
        tbl.push_back(mk("reset1",     0, 1, 0, 0, 0, 32'h0,        ADDI,   32'h0,        32'h0,  32'h0,        0, 0,  0));
        tbl.push_back(mk("run_0",      0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h4,        ADDI,   32'h4,        1, 0,  0));
        tbl.push_back(mk("run_lw",     0, 0, 0, 0, 0, 32'h0,        LW,     32'h8,        LW,     32'h8,        1, 0,  0));
        tbl.push_back(mk("lu_bubble",  0, 0, 1, 0, 0, 32'h0,        ADDI,   32'h8,        32'h0,  32'h8,        0, 1,  0));
        tbl.push_back(mk("lu_resume",  0, 0, 0, 0, 0, 32'h0,        ADDI,   32'hC,        ADDI,   32'hC,        1, 1,  0));
        tbl.push_back(mk("run_beq",    0, 0, 0, 0, 0, 32'h0,        BEQ,    32'h10,       BEQ,    32'h10,       1, 1,  0));
        tbl.push_back(mk("beq_enter",  0, 0, 1, 0, 0, 32'h0,        ADDI,   32'h10,       32'h0,  32'h10,       0, 2,  0));
        tbl.push_back(mk("beq_wait",   0, 0, 1, 0, 0, 32'h0,        ADDI,   32'h10,       32'h0,  32'h10,       0, 3,  0));
        tbl.push_back(mk("beq_taken",  0, 0, 0, 1, 1, 32'h40,       ADDI,   32'h40,       32'h0,  32'h10,       0, 4,  0));
        tbl.push_back(mk("tgt_fetch",  0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h44,       ADDI,   32'h44,       1, 4,  0));
        tbl.push_back(mk("res_in_run", 0, 0, 0, 1, 1, 32'h100,      BNE,    32'h48,       BNE,    32'h48,       1, 4,  0));
        tbl.push_back(mk("bne_enter",  0, 0, 1, 0, 0, 32'h0,        ADDI,   32'h48,       32'h0,  32'h48,       0, 5,  0));
        tbl.push_back(mk("bne_nt",     0, 0, 0, 1, 0, 32'h200,      ADDI,   32'h48,       32'h0,  32'h48,       0, 6,  0));
        tbl.push_back(mk("nt_fetch",   0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h4C,       ADDI,   32'h4C,       1, 6,  0));
        tbl.push_back(mk("run_regimm", 0, 0, 0, 0, 0, 32'h0,        REGIMM, 32'h50,       REGIMM, 32'h50,       1, 6,  0));
        tbl.push_back(mk("rgm_enter",  0, 0, 1, 0, 0, 32'h0,        ADDI,   32'h50,       32'h0,  32'h50,       0, 7,  0));
        tbl.push_back(mk("rgm_w1",     0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h50,       32'h0,  32'h50,       0, 8,  0));
        tbl.push_back(mk("rgm_w2",     0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h50,       32'h0,  32'h50,       0, 9,  0));
        tbl.push_back(mk("rgm_w3",     0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h50,       32'h0,  32'h50,       0, 10, 0));
        tbl.push_back(mk("rgm_w4_res", 0, 0, 0, 1, 1, 32'h103,      ADDI,   32'h100,      32'h0,  32'h50,       0, 11, 0));
        tbl.push_back(mk("rgm_fetch",  0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h104,      ADDI,   32'h104,      1, 11, 0));
        tbl.push_back(mk("run_bgtz",   0, 0, 0, 0, 0, 32'h0,        BGTZ,   32'h108,      BGTZ,   32'h108,      1, 11, 0));
        tbl.push_back(mk("bgtz_enter", 0, 0, 1, 0, 0, 32'h0,        ADDI,   32'h108,      32'h0,  32'h108,      0, 12, 0));
        tbl.push_back(mk("bgtz_w1",    0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h108,      32'h0,  32'h108,      0, 13, 0));
        tbl.push_back(mk("bgtz_w2",    0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h108,      32'h0,  32'h108,      0, 14, 0));
        tbl.push_back(mk("bgtz_w3",    0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h108,      32'h0,  32'h108,      0, 15, 0));
        tbl.push_back(mk("bgtz_tmo",   0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h108,      32'h0,  32'h108,      0, 16, 1));
        tbl.push_back(mk("tmo_fetch",  0, 0, 0, 0, 0, 32'h0,        ADDI,   32'h10C,      ADDI,   32'h10C,      1, 16, 1));
        tbl.push_back(mk("tmo_sticky", 0, 0, 0, 1, 0, 32'h0,        ADDI,   32'h110,      ADDI,   32'h110,      1, 16, 1));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset during the second BR_WAIT cycle abandons the branch.
        step(mk("rw_beq",      0, 0, 0, 0, 0, 32'h0,  BEQ,  32'h114, BEQ,   32'h114, 1, 16, 1));
        step(mk("rw_enter",    0, 0, 1, 0, 0, 32'h0,  ADDI, 32'h114, 32'h0, 32'h114, 0, 17, 1));
        step(mk("rw_w1",       0, 0, 0, 0, 0, 32'h0,  ADDI, 32'h114, 32'h0, 32'h114, 0, 18, 1));
        step(mk("rw_reset",    0, 1, 0, 0, 0, 32'h0,  ADDI, 32'h0,   32'h0, 32'h0,   0, 0,  0));
        step(mk("rw_stray",    0, 0, 0, 1, 1, 32'h80, ADDI, 32'h4,   ADDI,  32'h4,   1, 0,  0));
        step(mk("rw_lu",       0, 0, 1, 0, 0, 32'h0,  ADDI, 32'h4,   32'h0, 32'h4,   0, 1,  0));
        step(mk("rw_run",      0, 0, 0, 0, 0, 32'h0,  ADDI, 32'h8,   ADDI,  32'h8,   1, 1,  0));

        // Second instance: PC wrap, MAX_WAIT=1 timeout, 3-bit counter saturation.
        step(mk("d2_reset",    1, 1, 0, 0, 0, 32'h0,  ADDI, 32'hFFFF_FFF8, NOP2, 32'h0,         0, 0, 0));
        step(mk("d2_fetch",    1, 0, 0, 0, 0, 32'h0,  ADDI, 32'hFFFF_FFFC, ADDI, 32'hFFFF_FFFC, 1, 0, 0));
        step(mk("d2_wrap",     1, 0, 0, 0, 0, 32'h0,  BEQ,  32'h0,         BEQ,  32'h0,         1, 0, 0));
        step(mk("d2_enter",    1, 0, 1, 0, 0, 32'h0,  ADDI, 32'h0,         NOP2, 32'h0,         0, 1, 0));
        step(mk("d2_tmo",      1, 0, 0, 0, 0, 32'h0,  ADDI, 32'h0,         NOP2, 32'h0,         0, 2, 1));
        step(mk("d2_fetch2",   1, 0, 0, 0, 0, 32'h0,  ADDI, 32'h4,         ADDI, 32'h4,         1, 2, 1));
        for (int k = 3; k <= 9; k++) begin
            step(mk($sformatf("d2_sat%0d", k), 1, 0, 1, 0, 0, 32'h0, ADDI,
                    32'h4, NOP2, 32'h4, 0, (k > 7) ? 7 : k, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
